// File: rtl/fazyrv_ram_arb_pkg.sv
// Shared types and grant helper for the FazyRV single-port RAM arbiter.
// Used by fazyrv_ram_arb and fazyrv_rr_arbiter.
package fazyrv_ram_arb_pkg;

    typedef enum logic [0:0] {
        ARB,
        LOCKED
    } arb_state_e;

    // Widest requester vector the grant helper handles
    localparam int unsigned MAXN   = 8;
    localparam int unsigned MAXIDW = 3;

    // One-hot grant to the first valid requester at or after ptr, wrapping modulo n.
    function automatic logic [MAXN-1:0] rr_pick(input logic [MAXN-1:0] valid,
                                                input int unsigned     ptr,
                                                input int unsigned     n);
        logic [MAXN-1:0]   gnt;
        logic              found;
        logic [MAXIDW-1:0] idx;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAXN; i++) begin
            idx = MAXIDW'((ptr + i) % n);
            if ((i < n) && !found && valid[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/fazyrv_rr_arbiter.sv
// Combinational grant selection: round-robin from a pointer, or owner-only while locked.
// A zero pointer turns the round-robin pick into fixed lowest-index priority.
module fazyrv_rr_arbiter
    import fazyrv_ram_arb_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [IDW-1:0]  i_ptr,
    input  logic            i_locked,
    input  logic [IDW-1:0]  i_owner,
    output logic [NREQ-1:0] o_grant
);

    logic [MAXN-1:0] w_valid8;
    logic [MAXN-1:0] w_pick;

    always_comb begin
        w_valid8             = '0;
        w_valid8[NREQ-1:0]   = i_valid;
        w_pick               = rr_pick(w_valid8, 32'(i_ptr), NREQ);
        o_grant              = '0;
        if (i_locked) begin
            for (int k = 0; k < NREQ; k++) begin
                if (IDW'(k) == i_owner) begin
                    o_grant[k] = i_valid[k];
                end
            end
        end else begin
            o_grant = w_pick[NREQ-1:0];
        end
    end

    // Padding bits beyond NREQ are always zero since the valid vector is zero-padded
    if (NREQ < MAXN) begin : g_pad
        logic w_unused_pick;
        assign w_unused_pick = |w_pick[MAXN-1:NREQ];
    end

endmodule

// File: rtl/fazyrv_ram_arb.sv
// Arbitrates NREQ valid/ready requesters onto one single-port RAM port, with locked sequences.
// Define FAZYRV_RAM_ARB_PRIO_EN for fixed lowest-index priority instead of round-robin.
module fazyrv_ram_arb
    import fazyrv_ram_arb_pkg::*;
#(
    parameter int unsigned REGW = 32,
    parameter int unsigned ADRW = 5,
    parameter int unsigned NREQ = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ-1:0]      req_we_i,
    input  logic [NREQ-1:0]      req_lock_i,
    input  logic [NREQ*ADRW-1:0] req_addr_i,
    input  logic [NREQ*REGW-1:0] req_wdata_i,
    output logic [NREQ-1:0]      rsp_valid_o,
    output logic [REGW-1:0]      rsp_rdata_o,
    output logic                 ram_we_o,
    output logic [ADRW-1:0]      ram_waddr_o,
    output logic [ADRW-1:0]      ram_raddr_o,
    output logic [REGW-1:0]      ram_wdata_o,
    input  logic [REGW-1:0]      ram_rdata_i
);

    localparam int unsigned    IDW  = $clog2(NREQ);
    localparam logic [IDW-1:0] LAST = IDW'(NREQ - 1);

    arb_state_e      r_state;
    logic [IDW-1:0]  r_owner;
    logic [NREQ-1:0] r_rsp_valid;

    logic [IDW-1:0]  w_ptr;
    logic            w_locked;
    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_gnt_idx;
    logic [IDW-1:0]  w_nxt_ptr;
    logic [IDW-1:0]  w_sel;
    logic            w_accept;
    logic            w_sel_we;
    logic            w_sel_lock;
    logic [ADRW-1:0] w_sel_addr;
    logic [REGW-1:0] w_sel_wdata;

`ifdef FAZYRV_RAM_ARB_PRIO_EN
    assign w_ptr = '0;
`else
    logic [IDW-1:0] r_ptr;
    assign w_ptr = r_ptr;
`endif

    assign w_locked = (r_state == LOCKED);

    fazyrv_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arbiter (
        .i_valid  (req_valid_i),
        .i_ptr    (w_ptr),
        .i_locked (w_locked),
        .i_owner  (r_owner),
        .o_grant  (w_grant)
    );

    always_comb begin
        w_gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_grant[k]) begin
                w_gnt_idx = IDW'(k);
            end
        end
    end

    assign w_accept  = (|w_grant) && !rst_i;
    assign w_nxt_ptr = (w_gnt_idx == LAST) ? '0 : w_gnt_idx + IDW'(1);

    // With no accept the RAM lines still follow whoever the arbiter would serve next
    always_comb begin
        if (w_accept) begin
            w_sel = w_gnt_idx;
        end else if (w_locked) begin
            w_sel = r_owner;
        end else begin
            w_sel = w_ptr;
        end
    end

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_lock  = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (IDW'(k) == w_sel) begin
                w_sel_we    = req_we_i[k];
                w_sel_lock  = req_lock_i[k];
                w_sel_addr  = req_addr_i[k*ADRW +: ADRW];
                w_sel_wdata = req_wdata_i[k*REGW +: REGW];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ARB;
            r_owner     <= '0;
            r_rsp_valid <= '0;
`ifndef FAZYRV_RAM_ARB_PRIO_EN
            r_ptr       <= '0;
`endif
        end else begin
            r_rsp_valid <= (w_accept && !w_sel_we) ? w_grant : '0;
            if (w_accept) begin
                if (w_sel_lock) begin
                    r_state <= LOCKED;
                    r_owner <= w_gnt_idx;
                end else begin
                    r_state <= ARB;
`ifndef FAZYRV_RAM_ARB_PRIO_EN
                    r_ptr   <= w_nxt_ptr;
`endif
                end
            end
        end
    end

`ifdef FAZYRV_RAM_ARB_PRIO_EN
    logic [IDW-1:0] w_unused_nxt_ptr;
    assign w_unused_nxt_ptr = w_nxt_ptr;
`endif

    assign req_ready_o = rst_i ? '0 : w_grant;
    assign ram_we_o    = w_accept && w_sel_we;
    assign ram_waddr_o = w_sel_addr;
    assign ram_raddr_o = w_sel_addr;
    assign ram_wdata_o = w_sel_wdata;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = ram_rdata_i;

endmodule

// File: tb/tb_fazyrv_ram_arb.sv
// Directed bench for fazyrv_ram_arb with a one-cycle-latency RAM model.
// Expectations switch to fixed priority when FAZYRV_RAM_ARB_PRIO_EN is defined.
module tb_fazyrv_ram_arb;

    localparam int unsigned REGW = 32;
    localparam int unsigned ADRW = 5;
    localparam int unsigned NREQ = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      valid;
    logic [NREQ-1:0]      ready;
    logic [NREQ-1:0]      we;
    logic [NREQ-1:0]      lock;
    logic [NREQ*ADRW-1:0] addr;
    logic [NREQ*REGW-1:0] wdata;
    logic [NREQ-1:0]      rsp_valid;
    logic [REGW-1:0]      rsp_rdata;
    logic                 ram_we;
    logic [ADRW-1:0]      ram_waddr;
    logic [ADRW-1:0]      ram_raddr;
    logic [REGW-1:0]      ram_wdata;
    logic [REGW-1:0]      ram_rdata;

    logic [REGW-1:0] mem [32];

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        ram_rdata <= mem[ram_raddr];
    end

    fazyrv_ram_arb #(
        .REGW (REGW),
        .ADRW (ADRW),
        .NREQ (NREQ)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (valid),
        .req_ready_o (ready),
        .req_we_i    (we),
        .req_lock_i  (lock),
        .req_addr_i  (addr),
        .req_wdata_i (wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .ram_we_o    (ram_we),
        .ram_waddr_o (ram_waddr),
        .ram_raddr_o (ram_raddr),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_all();
        valid = '0;
        we    = '0;
        lock  = '0;
    endtask

    task automatic set_req(input int k, input logic v, input logic w, input logic l,
                           input logic [ADRW-1:0] a, input logic [REGW-1:0] d);
        valid[k]                = v;
        we[k]                   = w;
        lock[k]                 = l;
        addr[k*ADRW +: ADRW]    = a;
        wdata[k*REGW +: REGW]   = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_all();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [NREQ-1:0] exp_gnt [4];
    logic [NREQ-1:0] prev;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[3] = 32'hDEADBEEF;
        mem[5] = 32'hA5A50005;
        addr   = '0;
        wdata  = '0;
        idle_all();
`ifdef FAZYRV_RAM_ARB_PRIO_EN
        exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif

        // Held in reset with a write pending: nothing may be granted or written
        set_req(0, 1'b1, 1'b1, 1'b0, 5'd3, 32'h0BAD0BAD);
        @(negedge clk); #1;
        check("rst_ready", ready, 2'b00);
        check("rst_ram_we", ram_we, 1'b0);
        check("rst_rsp_valid", rsp_valid, 2'b00);

        // Single read
        @(negedge clk);
        rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 1'b0, 5'd3, 32'h0);
        #1;
        check("rd_ready", ready, 2'b01);
        check("rd_raddr", ram_raddr, 5'd3);
        check("rd_ram_we", ram_we, 1'b0);
        @(negedge clk);
        idle_all();
        #1;
        check("rd_rsp_valid", rsp_valid, 2'b01);
        check("rd_rdata", rsp_rdata, 32'hDEADBEEF);
        check("idle_ready", ready, 2'b00);

        // Both requesters reading continuously
        do_reset();
        prev = '0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            set_req(0, 1'b1, 1'b0, 1'b0, 5'd3, 32'h0);
            set_req(1, 1'b1, 1'b0, 1'b0, 5'd5, 32'h0);
            #1;
            check($sformatf("arb_ready%0d", i), ready, exp_gnt[i]);
            check($sformatf("arb_raddr%0d", i), ram_raddr, (exp_gnt[i] == 2'b01) ? 5'd3 : 5'd5);
            check($sformatf("arb_rsp_valid%0d", i), rsp_valid, prev);
            if (prev != 2'b00)
                check($sformatf("arb_rdata%0d", i), rsp_rdata,
                      (prev == 2'b01) ? 32'hDEADBEEF : 32'hA5A50005);
            prev = exp_gnt[i];
        end
        @(negedge clk);
        idle_all();
        #1;
        check("arb_rsp_valid_last", rsp_valid, prev);
        check("arb_rdata_last", rsp_rdata, (prev == 2'b01) ? 32'hDEADBEEF : 32'hA5A50005);

        // Write then read the same address back-to-back
        @(negedge clk);
        set_req(1, 1'b1, 1'b1, 1'b0, 5'd7, 32'h12345678);
        #1;
        check("wr_ready", ready, 2'b10);
        check("wr_ram_we", ram_we, 1'b1);
        check("wr_waddr", ram_waddr, 5'd7);
        check("wr_wdata", ram_wdata, 32'h12345678);
        @(negedge clk);
        set_req(1, 1'b1, 1'b0, 1'b0, 5'd7, 32'h0);
        #1;
        check("raw_ready", ready, 2'b10);
        check("raw_ram_we", ram_we, 1'b0);
        check("wr_no_rsp", rsp_valid, 2'b00);
        @(negedge clk);
        idle_all();
        #1;
        check("raw_rsp_valid", rsp_valid, 2'b10);
        check("raw_rdata", rsp_rdata, 32'h12345678);

        // Locked read-modify-write by req0 while req1 waits
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 1'b1, 5'd2, 32'h0);
        set_req(1, 1'b1, 1'b0, 1'b0, 5'd5, 32'h0);
        #1;
        check("lk_ready0", ready, 2'b01);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            set_req(0, 1'b0, 1'b0, 1'b0, 5'd2, 32'h0);
            #1;
            check($sformatf("lk_hold%0d", i), ready, 2'b00);
        end
        @(negedge clk);
        set_req(0, 1'b1, 1'b1, 1'b0, 5'd2, 32'hCAFEF00D);
        #1;
        check("lk_wr_ready", ready, 2'b01);
        check("lk_wr_we", ram_we, 1'b1);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 1'b0, 5'd2, 32'h0);
        #1;
        check("lk_release", ready, 2'b10);
        @(negedge clk);
        idle_all();
        #1;
        check("lk_rsp1", rsp_valid, 2'b10);
        check("lk_mem2", mem[2], 32'hCAFEF00D);

        // Reset between a locked read accept and its response
        do_reset();
        set_req(1, 1'b1, 1'b0, 1'b1, 5'd5, 32'h0);
        #1;
        check("mr_ready", ready, 2'b10);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mr_rsp_dropped", rsp_valid, 2'b00);
        check("mr_ready_rst", ready, 2'b00);
        #1;
        rst = 1'b0;
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 1'b0, 5'd3, 32'h0);
        set_req(1, 1'b1, 1'b0, 1'b0, 5'd5, 32'h0);
        #1;
        check("mr_first_grant", ready, 2'b01);
        @(negedge clk);
        idle_all();
        #1;
        check("mr_rsp", rsp_valid, 2'b01);
        check("mr_rdata", rsp_rdata, 32'hDEADBEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
